// File: rtl/seg_dec_conv.sv
// seg_dec_conv: binary to 7-segment decimal converter using a sequential double-dabble engine,
// with leading-zero blanking, minus sign, decimal-overflow detection and an error display.
module seg_dec_conv #(
   parameter int NUM_W    = 14,
   parameter int DIGITS   = 4,
   parameter bit SIGNED   = 0,
   parameter bit BLANK_LZ = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_W-1:0]    num,
   input  logic                convert,
   input  logic                error,
   output logic [8*DIGITS-1:0] digits,
   output logic                conv_done,
   output logic                busy,
   output logic                overflow
);
   localparam int ND = NUM_W/3 + 1;
   localparam int SW = 4*ND + NUM_W;
   localparam int AV = DIGITS - int'(SIGNED);
   localparam int NX = ND > DIGITS ? ND : DIGITS;
   localparam int CW = $clog2(NUM_W + 1);
   localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, ENC = 2'd2, ERR = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW-1:0]       sh_q, sh_d, adj;
   logic                neg_q, neg_d;
   logic [8*DIGITS-1:0] digits_q, digits_d, enc, err_pat;
   logic                done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
   logic [4*NX-1:0]     bcd_x;
   logic                enc_ovf, seen;

   function automatic logic [7:0] seg(input logic [3:0] n);
      case (n)
         4'd0: return 8'h3F;
         4'd1: return 8'h06;
         4'd2: return 8'h5B;
         4'd3: return 8'h4F;
         4'd4: return 8'h66;
         4'd5: return 8'h6D;
         4'd6: return 8'h7D;
         4'd7: return 8'h07;
         4'd8: return 8'h7F;
         4'd9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      neg_d    = neg_q;
      digits_d = digits_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      err_pat  = '0;
      err_pat[31:0] = 32'h763D507C;
      adj = sh_q;
      for (int k = 0; k < ND; k++)
         if (adj[NUM_W+4*k +: 4] >= 4'd5) adj[NUM_W+4*k +: 4] = adj[NUM_W+4*k +: 4] + 4'd3;
      // zero-extend so digit positions beyond the BCD field read as 0
      bcd_x = '0;
      bcd_x[4*ND-1:0] = sh_q[SW-1 -: 4*ND];
      enc_ovf = 1'b0;
      for (int k = 0; k < NX; k++)
         if (k >= AV && bcd_x[4*k +: 4] != 4'd0) enc_ovf = 1'b1;
      enc  = '0;
      seen = 1'b0;
      for (int k = DIGITS-1; k >= 0; k--)
         if (k < AV) begin
            seen = seen | (bcd_x[4*k +: 4] != 4'd0) | (k == 0);
            enc[8*k +: 8] = (BLANK_LZ && !seen) ? 8'h00 : seg(bcd_x[4*k +: 4]);
         end
      if (SIGNED) enc[8*DIGITS-1 -: 8] = neg_q ? 8'h40 : 8'h00;
      case (state_q)
         IDLE:
            if (error) state_d = ERR;
            else if (convert) begin
               state_d = CONV;
               cnt_d   = '0;
               neg_d   = SIGNED && num[NUM_W-1];
               sh_d    = {{(4*ND){1'b0}}, neg_d ? -num : num};
            end
         CONV: begin
            sh_d    = adj << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(NUM_W-1)) ? ENC : CONV;
         end
         ENC: begin
            digits_d = enc_ovf ? err_pat : enc;
            ovf_d    = enc_ovf;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            digits_d = err_pat;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         neg_q    <= 1'b0;
         digits_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         neg_q    <= neg_d;
         digits_q <= digits_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end

   assign digits    = digits_q;
   assign conv_done = done_q;
   assign busy      = busy_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_seg_dec_conv.sv
// tb_seg_dec_conv: scoreboard bench for seg_dec_conv across default, no-blanking and signed builds.
module tb_seg_dec_conv;
   typedef struct { int u; logic [31:0] d; logic o; int t; } exp_t;
   localparam logic [31:0] EP = 32'h763D507C;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [13:0] num [3];
   logic        cv [3], er [3], dn [3], bz [3], ov [3];
   logic [31:0] dg [3];
   exp_t        q [$];
   int          cyc = 0, checks = 0, errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seg_dec_conv u0 (.clk(clk), .rst_n(rst_n), .num(num[0]), .convert(cv[0]), .error(er[0]),
                    .digits(dg[0]), .conv_done(dn[0]), .busy(bz[0]), .overflow(ov[0]));
   seg_dec_conv #(.BLANK_LZ(0)) u1 (.clk(clk), .rst_n(rst_n), .num(num[1]), .convert(cv[1]), .error(er[1]),
                    .digits(dg[1]), .conv_done(dn[1]), .busy(bz[1]), .overflow(ov[1]));
   seg_dec_conv #(.SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .num(num[2]), .convert(cv[2]), .error(er[2]),
                    .digits(dg[2]), .conv_done(dn[2]), .busy(bz[2]), .overflow(ov[2]));

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, a, e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int u = 0; u < 3; u++)
         if (dn[u] === 1'b1) begin
            if (q.size() == 0 || q[0].u != u) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: unit %0d conv_done got 1 required 0", u);
            end else begin
               e = q.pop_front();
               chk("digits", dg[u], e.d);
               chk("overflow", ov[u], e.o);
               chk("done_time", cyc, e.t);
            end
         end
   end

   // poke pulses error and convert mid-conversion; num is scrambled after capture
   task automatic conv(input int u, input logic [13:0] n, input logic [31:0] d, input logic o, input bit poke);
      int b = 0;
      @(negedge clk);
      num[u] = n;
      cv[u]  = 1'b1;
      q.push_back('{u, d, o, cyc + 16});
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         cv[u]  = 1'b0;
         er[u]  = 1'b0;
         num[u] = 14'($urandom);
         if (poke && i == 4) begin
            er[u] = 1'b1;
            cv[u] = 1'b1;
         end
         b += int'(bz[u]);
      end
      chk("busy_cycles", b, 15);
   endtask

   task automatic errt(input int u, input logic o);
      int b = 0;
      @(negedge clk);
      er[u]  = 1'b1;
      cv[u]  = 1'b1;
      num[u] = 14'd5;
      q.push_back('{u, EP, o, cyc + 2});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         er[u] = 1'b0;
         cv[u] = 1'b0;
         b += int'(bz[u]);
      end
      chk("err_busy", b, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 3; u++) begin
         num[u] = '0;
         cv[u]  = 1'b0;
         er[u]  = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) chk("reset_state", {dg[u], dn[u], bz[u], ov[u]}, 64'h0);
      rst_n = 1'b1;
      conv(0, 14'd1234,  32'h065B4F66, 1'b0, 1'b0);
      conv(0, 14'd7,     32'h00000007, 1'b0, 1'b0);
      conv(0, 14'd0,     32'h0000003F, 1'b0, 1'b0);
      conv(0, 14'd12345, EP,           1'b1, 1'b0);
      conv(0, 14'd9999,  32'h6F6F6F6F, 1'b0, 1'b0);
      errt(0, 1'b0);
      conv(0, 14'd4321,  32'h664F5B06, 1'b0, 1'b1);
      conv(1, 14'd7,     32'h3F3F3F07, 1'b0, 1'b0);
      conv(1, 14'd0,     32'h3F3F3F3F, 1'b0, 1'b0);
      conv(1, 14'd12345, EP,           1'b1, 1'b0);
      conv(2, 14'h3FD6,  32'h4000665B, 1'b0, 1'b0);
      conv(2, 14'd999,   32'h006F6F6F, 1'b0, 1'b0);
      conv(2, 14'h2000,  EP,           1'b1, 1'b0);
      errt(2, 1'b1);
      conv(2, 14'h3FF9,  32'h40000007, 1'b0, 1'b0);
      @(negedge clk);
      num[0] = 14'd1234;
      cv[0]  = 1'b1;
      repeat (5) @(negedge clk) cv[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {dg[0], dn[0], bz[0], ov[0]}, 64'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      conv(0, 14'd56, 32'h00006D7D, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("pending", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
